// File: rtl/system_pkg.sv
// Shared definitions for the multi-core system: default widths and the
// arbiter FSM state encoding.
package system_pkg;

  localparam int CORE_COUNT_DEF  = 3;
  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int REG_WIDTH_DEF   = 12;
  localparam int MEM_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin select: first set request after ptr, wrapping,
// with ptr itself checked last.
module rr_priority_picker #(
  parameter int n_req     = 3,
  parameter int idx_width = 2
) (
  input  logic [n_req-1:0]     req,
  input  logic [idx_width-1:0] ptr,
  output logic [idx_width-1:0] grant,
  output logic                 any_req
);

  logic [idx_width-1:0] cand;

  // Scan from the furthest position down so the closest requester after ptr wins.
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int k = n_req; k >= 1; k--) begin
      cand = idx_width'((int'(ptr) + k) % n_req);
      if (req[cand]) grant = cand;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between several
// cores: serialises requests, drives the memory port and acks each core.
module shared_mem_arbiter
  import system_pkg::*;
#(
  parameter int core_count  = CORE_COUNT_DEF,
  parameter int addr_width  = ADDR_WIDTH_DEF,
  parameter int reg_width   = REG_WIDTH_DEF,
  parameter int mem_latency = MEM_LATENCY_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            core_req,
  input  logic [core_count-1:0]            core_we,
  input  logic [core_count*addr_width-1:0] core_addr,
  input  logic [core_count*reg_width-1:0]  core_wdata,
  output logic [core_count-1:0]            core_ack,
  output logic [reg_width-1:0]             core_rdata,
  output logic [$clog2(core_count)-1:0]    grant_id,
  output logic                             busy,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [addr_width-1:0]            mem_addr,
  output logic [reg_width-1:0]             mem_wdata,
  input  logic [reg_width-1:0]             mem_rdata
);

  localparam int idx_width = $clog2(core_count);
  localparam int cnt_width = $clog2(mem_latency + 1);

  arb_state_t           state_reg, state_next;
  logic [idx_width-1:0] grant_reg, grant_next;
  logic [idx_width-1:0] ptr_reg, ptr_next;
  logic [idx_width-1:0] pick_grant;
  logic                 any_req;
  logic [cnt_width-1:0] cnt_reg, cnt_next;
  logic [reg_width-1:0] rdata_reg, rdata_next;

  logic [addr_width-1:0] addr_arr  [core_count];
  logic [reg_width-1:0]  wdata_arr [core_count];

  generate
    for (genvar gi = 0; gi < core_count; gi++) begin : g_core
      assign addr_arr[gi]  = core_addr[gi*addr_width +: addr_width];
      assign wdata_arr[gi] = core_wdata[gi*reg_width +: reg_width];
      assign core_ack[gi]  = (state_reg == S_ACK) && (grant_reg == idx_width'(gi));
    end
  endgenerate

  rr_priority_picker #(
    .n_req     (core_count),
    .idx_width (idx_width)
  ) u_picker (
    .req     (core_req),
    .ptr     (ptr_reg),
    .grant   (pick_grant),
    .any_req (any_req)
  );

  // Pointer resets to the last core so core 0 has first priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      grant_reg <= '0;
      ptr_reg   <= idx_width'(core_count - 1);
      cnt_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          grant_next = pick_grant;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_we[grant_reg]) begin
          state_next = S_ACK;
        end else begin
          cnt_next   = cnt_width'(mem_latency);
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - cnt_width'(1);
        if (cnt_reg == cnt_width'(1)) begin
          rdata_next = mem_rdata;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        ptr_next   = grant_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_reg == S_ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = core_we[grant_reg];
      mem_addr  = addr_arr[grant_reg];
      mem_wdata = wdata_arr[grant_reg];
    end
  end

  assign grant_id   = grant_reg;
  assign busy       = (state_reg != S_IDLE);
  assign core_rdata = rdata_reg;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Randomised self-checking bench for shared_mem_arbiter against a
// transaction-level round-robin schedule model.
module tb_shared_mem_arbiter;

  localparam int NC  = 3;
  localparam int AW  = 8;
  localparam int DW  = 12;
  localparam int LAT = 2;

  typedef struct {
    int            core;
    int            start;
    int            ack;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NC-1:0]    core_req, core_we, core_ack;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [DW-1:0]    core_rdata, mem_wdata, mem_rdata;
  logic [1:0]       grant_id;
  logic             busy, mem_en, mem_we;
  logic [AW-1:0]    mem_addr;

  int checks = 0;
  int errors = 0;

  shared_mem_arbiter #(
    .core_count(NC), .addr_width(AW), .reg_width(DW), .mem_latency(LAT)
  ) u_dut (
    .clk(clk), .reset(rst_n), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
    .core_rdata(core_rdata), .grant_id(grant_id), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] rd_func(input logic [AW-1:0] a);
    return {a[3:0], a} ^ 12'h96C;
  endfunction

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'h10) ? 12'hABC : rd_func(a);
  endfunction

  // Memory seen by the main DUT: fixed-latency read pipeline.
  logic          dram_init;
  logic [DW-1:0] dram [256];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (dram_init) begin
      for (int i = 0; i < 256; i++) dram[i] <= init_val(8'(i));
    end else if (mem_en && mem_we) begin
      dram[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? dram[mem_addr] : 12'hEEE;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Two extra instances with latency 1 and 4.
  logic [NC-1:0]    x_req [2], x_we [2], x_ack [2];
  logic [NC*AW-1:0] x_addr [2];
  logic [NC*DW-1:0] x_wdata [2];
  logic [DW-1:0]    x_rdata [2], x_mwdata [2], x_mrdata [2];
  logic [1:0]       x_gid [2];
  logic             x_busy [2], x_men [2], x_mwe [2];
  logic [AW-1:0]    x_maddr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lat
      localparam int XL = (gi == 0) ? 1 : 4;
      logic [DW-1:0] pipe [XL];
      shared_mem_arbiter #(
        .core_count(NC), .addr_width(AW), .reg_width(DW), .mem_latency(XL)
      ) u_x (
        .clk(clk), .reset(rst_n), .core_req(x_req[gi]), .core_we(x_we[gi]),
        .core_addr(x_addr[gi]), .core_wdata(x_wdata[gi]), .core_ack(x_ack[gi]),
        .core_rdata(x_rdata[gi]), .grant_id(x_gid[gi]), .busy(x_busy[gi]),
        .mem_en(x_men[gi]), .mem_we(x_mwe[gi]), .mem_addr(x_maddr[gi]),
        .mem_wdata(x_mwdata[gi]), .mem_rdata(x_mrdata[gi])
      );
      always @(posedge clk) begin
        pipe[0] <= (x_men[gi] && !x_mwe[gi]) ? rd_func(x_maddr[gi]) : 12'hEEE;
        for (int k = 1; k < XL; k++) pipe[k] <= pipe[k-1];
      end
      assign x_mrdata[gi] = pipe[XL-1];
    end
  endgenerate

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  int            m_ptr;
  int            m_gid;
  logic [DW-1:0] m_rdata;
  txn_t          sched [$];

  logic          b_we [NC];
  logic [AW-1:0] b_addr [NC];
  logic [DW-1:0] b_wdata [NC];

  task automatic model_reset();
    m_ptr   = NC - 1;
    m_gid   = 0;
    m_rdata = '0;
  endtask

  task automatic pack_ops();
    for (int c = 0; c < NC; c++) begin
      core_we[c]             = b_we[c];
      core_addr[c*AW +: AW]  = b_addr[c];
      core_wdata[c*DW +: DW] = b_wdata[c];
    end
  endtask

  // Serve pending cores in rotating order; each transaction starts in an
  // IDLE cycle, and the next IDLE follows the ack cycle.
  task automatic plan(input logic [NC-1:0] mask, input logic [NC-1:0] rr);
    logic [NC-1:0] pend;
    logic [NC-1:0] rra;
    int            t;
    int            g;
    int            c;
    txn_t          tr;
    pend = mask;
    rra  = rr;
    t    = 0;
    sched.delete();
    while (pend != '0) begin
      g = -1;
      for (int s = 1; s <= NC; s++) begin
        c = (m_ptr + s) % NC;
        if (g < 0 && pend[c]) g = c;
      end
      tr.core  = g;
      tr.start = t;
      tr.we    = b_we[g];
      tr.addr  = b_addr[g];
      tr.wdata = b_wdata[g];
      tr.ack   = t + 2 + (tr.we ? 0 : LAT);
      if (tr.we) begin
        ref_mem[tr.addr] = tr.wdata;
        tr.rdata = '0;
      end else begin
        tr.rdata = ref_mem[tr.addr];
      end
      sched.push_back(tr);
      pend[g] = 1'b0;
      if (rra[g]) begin
        pend[g] = 1'b1;
        rra[g]  = 1'b0;
      end
      m_ptr = g;
      t     = tr.ack + 1;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // idle cycle following the last ack.
  task automatic run_batch(input logic [NC-1:0] mask, input logic [NC-1:0] rr, input string name);
    logic [NC-1:0] drv_rr, e_ack;
    logic          e_busy, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int            last;
    plan(mask, rr);
    drv_rr = rr;
    pack_ops();
    core_req = mask;
    last = sched[$].ack;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      e_ack = '0; e_busy = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      foreach (sched[j]) begin
        if (k > sched[j].start && k <= sched[j].ack) e_busy = 1'b1;
        if (k >= sched[j].start + 1) m_gid = sched[j].core;
        if (k == sched[j].start + 1) begin
          e_en = 1'b1; e_we = sched[j].we; e_addr = sched[j].addr; e_wd = sched[j].wdata;
        end
        if (k == sched[j].ack) begin
          e_ack[sched[j].core] = 1'b1;
          if (!sched[j].we) m_rdata = sched[j].rdata;
        end
      end
      checks++;
      if (core_ack !== e_ack) begin
        errors++;
        $display("FAIL %s cyc%0d core_ack got %b exp %b", name, k, core_ack, e_ack);
      end
      checks++;
      if (busy !== e_busy || grant_id !== 2'(m_gid)) begin
        errors++;
        $display("FAIL %s cyc%0d busy/grant got %b/%0d exp %b/%0d", name, k, busy, grant_id, e_busy, m_gid);
      end
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wd}) begin
        errors++;
        $display("FAIL %s cyc%0d mem en/we/addr/wd got %b/%b/%h/%h exp %b/%b/%h/%h",
                 name, k, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wd);
      end
      checks++;
      if (core_rdata !== m_rdata) begin
        errors++;
        $display("FAIL %s cyc%0d core_rdata got %h exp %h", name, k, core_rdata, m_rdata);
      end
      foreach (sched[j]) begin
        if (k == sched[j].ack) begin
          if (drv_rr[sched[j].core]) drv_rr[sched[j].core] = 1'b0;
          else core_req[sched[j].core] = 1'b0;
        end
      end
    end
    $display("txn %s: %0d transactions, last ack at cycle %0d", name, sched.size(), last);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({core_ack, core_rdata, grant_id, busy, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset outputs got ack=%b rd=%h gid=%0d busy=%b en=%b", core_ack, core_rdata, grant_id, busy, mem_en);
    end
    checks++;
    if (x_busy[0] !== 1'b0 || x_busy[1] !== 1'b0 || x_ack[0] !== '0 || x_ack[1] !== '0) begin
      errors++;
      $display("FAIL reset_lat busy got %b%b exp 00", x_busy[0], x_busy[1]);
    end
    dram_init = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    @(negedge clk);
    $display("txn reset: outputs idle");
  endtask

  task automatic test_single_read();
    b_we[1] = 1'b0; b_addr[1] = 8'h10; b_wdata[1] = 12'h000;
    run_batch(3'b010, 3'b000, "read_core1");
  endtask

  task automatic test_write_readback();
    b_we[2] = 1'b1; b_addr[2] = 8'h3F; b_wdata[2] = 12'h5A5;
    run_batch(3'b100, 3'b000, "write_core2");
    b_we[0] = 1'b0; b_addr[0] = 8'h3F; b_wdata[0] = 12'h000;
    run_batch(3'b001, 3'b000, "readback_core0");
  endtask

  task automatic test_all_contend();
    do_reset();
    for (int c = 0; c < NC; c++) begin
      b_we[c] = 1'b0; b_addr[c] = 8'(8'h20 + c); b_wdata[c] = '0;
    end
    run_batch(3'b111, 3'b000, "all_contend");
  endtask

  task automatic test_reraise();
    b_we[0] = 1'b1; b_addr[0] = 8'h55; b_wdata[0] = 12'h0F0;
    b_we[1] = 1'b0; b_addr[1] = 8'h55; b_wdata[1] = 12'h000;
    run_batch(3'b011, 3'b001, "reraise_core0");
  endtask

  task automatic test_reset_mid_wait();
    b_we[1] = 1'b0; b_addr[1] = 8'h20; b_wdata[1] = '0;
    pack_ops();
    core_req = 3'b010;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL midwait_state busy/en got %b/%b exp 1/0", busy, mem_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({core_ack, core_rdata, grant_id, busy, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL midwait_reset outputs got ack=%b rd=%h gid=%0d busy=%b en=%b", core_ack, core_rdata, grant_id, busy, mem_en);
    end
    core_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (core_ack !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midwait_noack cyc%0d ack/busy got %b/%b exp 000/0", k, core_ack, busy);
      end
    end
    b_we[2] = 1'b1; b_addr[2] = 8'h44; b_wdata[2] = 12'h321;
    run_batch(3'b100, 3'b000, "post_reset_write");
    b_we[2] = 1'b0;
    run_batch(3'b100, 3'b000, "post_reset_read");
  endtask

  task automatic test_random();
    logic [NC-1:0] mask, rr;
    for (int n = 0; n < 25; n++) begin
      for (int c = 0; c < NC; c++) begin
        b_we[c]    = 1'($urandom_range(0, 1));
        b_addr[c]  = 8'($urandom_range(0, 15));
        b_wdata[c] = 12'($urandom);
      end
      mask = 3'($urandom_range(1, 7));
      rr   = 3'($urandom_range(0, 7)) & mask;
      run_batch(mask, rr, $sformatf("random%0d", n));
    end
  endtask

  task automatic test_latency();
    logic [AW-1:0] a;
    int            lat;
    a = 8'h2B;
    for (int g = 0; g < 2; g++) begin
      x_addr[g] = {16'h0000, a}; x_wdata[g] = '0; x_we[g] = 3'b000; x_req[g] = 3'b001;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        lat = (g == 0) ? 1 : 4;
        checks++;
        if (x_ack[g] !== ((k == 2 + lat) ? 3'b001 : 3'b000) || x_men[g] !== (k == 1)) begin
          errors++;
          $display("FAIL lat%0d_read cyc%0d ack/en got %b/%b", lat, k, x_ack[g], x_men[g]);
        end
        if (k == 2 + lat) begin
          checks++;
          if (x_rdata[g] !== rd_func(a)) begin
            errors++;
            $display("FAIL lat%0d_rdata got %h exp %h", lat, x_rdata[g], rd_func(a));
          end
          x_req[g] = '0;
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      x_we[g] = 3'b010; x_addr[g] = {8'h00, 8'h61, 8'h00}; x_wdata[g] = {12'h000, 12'h7E1, 12'h000};
      x_req[g] = 3'b010;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (x_ack[g] !== ((k == 2) ? 3'b010 : 3'b000) || x_men[g] !== (k == 1) ||
            (k == 1 && (x_mwe[g] !== 1'b1 || x_maddr[g] !== 8'h61 || x_mwdata[g] !== 12'h7E1))) begin
          errors++;
          $display("FAIL lat_inst%0d_write cyc%0d ack/en/we got %b/%b/%b", g, k, x_ack[g], x_men[g], x_mwe[g]);
        end
        if (k == 2) x_req[g] = '0;
      end
    end
    $display("txn latency: read acks checked at cycles 3 and 6, writes at cycle 2");
  endtask

  initial begin
    rst_n = 1'b0;
    dram_init = 1'b1;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    for (int g = 0; g < 2; g++) begin
      x_req[g] = '0; x_we[g] = '0; x_addr[g] = '0; x_wdata[g] = '0;
    end
    for (int c = 0; c < NC; c++) begin
      b_we[c] = 1'b0; b_addr[c] = '0; b_wdata[c] = '0;
    end
    model_reset();
    test_reset();
    test_single_read();
    test_write_readback();
    test_all_contend();
    test_reraise();
    test_reset_mid_wait();
    test_random();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
